// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Control/status bus between the PC sequencer and the up/down counter it drives.
//   cnt_reset     : counter reset, active-high (sequencer -> counter)
//   cnt_setvalue  : counter load strobe (sequencer -> counter)
//   cnt_decrement : counter direction, 1 = count down (sequencer -> counter)
//   cnt_valuein   : counter load value (sequencer -> counter)
//   cnt_valueout  : current counter value (counter -> sequencer)
interface pc_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cnt_reset;
    logic             cnt_setvalue;
    logic             cnt_decrement;
    logic [WIDTH-1:0] cnt_valuein;
    logic [WIDTH-1:0] cnt_valueout;

    modport master (
        output cnt_reset,
        output cnt_setvalue,
        output cnt_decrement,
        output cnt_valuein,
        input  cnt_valueout
    );

    modport slave (
        input  cnt_reset,
        input  cnt_setvalue,
        input  cnt_decrement,
        input  cnt_valuein,
        output cnt_valueout
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Drives an external up/down counter used as the program counter. Decodes
// step / rewind / jump / call / ret requests into counter controls, keeps a
// DEPTH-entry return-address stack and a RUN / HALTED / FAULT state machine.
// The counter has no hold input, so holding is done by reloading its own value.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   step, rewind        : PC +1 / PC -1
//   jump, call, ret     : load target / push return address and load target / pop
//   target              : jump/call destination
//   halt, resume, clear : enter HALTED / leave HALTED / leave FAULT and empty stack
//   cnt                 : counter control bus (master side)
//   pc                  : current PC (the counter value)
//   depth               : return-stack occupancy
//   halted, fault       : state flags
module pc_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     step,
    input  logic                     rewind,
    input  logic                     jump,
    input  logic                     call,
    input  logic                     ret,
    input  logic [WIDTH-1:0]         target,
    input  logic                     halt,
    input  logic                     resume,
    input  logic                     clear,
    pc_sequencer_if.master           cnt,
    output logic [WIDTH-1:0]         pc,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     halted,
    output logic                     fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    // Exactly one counter action per cycle; the counter is never left idle.
    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_STEP   = 2'd1,
        ACT_REWIND = 2'd2,
        ACT_LOAD   = 2'd3
    } act_t;

    state_t           state_reg, state_next;
    logic [DW-1:0]    depth_reg, depth_next;
    act_t             act;
    logic [WIDTH-1:0] load_value;
    logic             push;
    logic [WIDTH-1:0] ret_addr;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] stack_q [DEPTH];

    assign ret_addr = cnt.cnt_valueout + WIDTH'(1);
    // When full the low bits wrap to 0, but a push is never issued then.
    assign wr_idx   = depth_reg[AW-1:0];
    assign top_idx  = depth_reg[AW-1:0] - AW'(1);

    // ------------------------------------------------------------------
    // Return-address stack, one register per entry
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stack
            localparam logic [AW-1:0] ENTRY_IDX = AW'(gi);
            logic [WIDTH-1:0] entry_reg;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    entry_reg <= '0;
                end else if (push && (wr_idx == ENTRY_IDX)) begin
                    entry_reg <= ret_addr;
                end
            end

            assign stack_q[gi] = entry_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and occupancy registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RUN;
            depth_reg <= '0;
        end else begin
            state_reg <= state_next;
            depth_reg <= depth_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / action decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        depth_next = depth_reg;
        act        = ACT_HOLD;
        load_value = target;
        push       = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (halt) begin
                    state_next = ST_HALTED;
                end else if (ret) begin
                    if (depth_reg != '0) begin
                        act        = ACT_LOAD;
                        load_value = stack_q[top_idx];
                        depth_next = depth_reg - DW'(1);
                    end else begin
                        state_next = ST_FAULT;
                    end
                end else if (call) begin
                    if (depth_reg != DEPTH_FULL) begin
                        act        = ACT_LOAD;
                        push       = 1'b1;
                        depth_next = depth_reg + DW'(1);
                    end else begin
                        state_next = ST_FAULT;
                    end
                end else if (jump) begin
                    act = ACT_LOAD;
                end else if (rewind) begin
                    act = ACT_REWIND;
                end else if (step) begin
                    act = ACT_STEP;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_next = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (clear) begin
                    state_next = ST_RUN;
                    depth_next = '0;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counter control encoding
    // ------------------------------------------------------------------
    // Combinational so the counter clears together with this block.
    assign cnt.cnt_reset = ~reset;

    always_comb begin
        cnt.cnt_setvalue  = 1'b1;
        cnt.cnt_decrement = 1'b0;
        cnt.cnt_valuein   = cnt.cnt_valueout;
        case (act)
            ACT_STEP: begin
                cnt.cnt_setvalue = 1'b0;
            end
            ACT_REWIND: begin
                cnt.cnt_setvalue  = 1'b0;
                cnt.cnt_decrement = 1'b1;
            end
            ACT_LOAD: begin
                cnt.cnt_valuein = load_value;
            end
            default: begin
            end
        endcase
    end

    assign pc     = cnt.cnt_valueout;
    assign depth  = depth_reg;
    assign halted = (state_reg == ST_HALTED);
    assign fault  = (state_reg == ST_FAULT);
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Drives pc_sequencer against a behavioural up/down counter. Expected
// pc/depth/halted/fault values are pushed to a scoreboard queue as each
// request is driven and popped after the clock edge that applies it.
module tb_pc_sequencer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    localparam bit [7:0] R_NONE   = 8'h00;
    localparam bit [7:0] R_STEP   = 8'h01;
    localparam bit [7:0] R_REW    = 8'h02;
    localparam bit [7:0] R_JUMP   = 8'h04;
    localparam bit [7:0] R_CALL   = 8'h08;
    localparam bit [7:0] R_RET    = 8'h10;
    localparam bit [7:0] R_HALT   = 8'h20;
    localparam bit [7:0] R_RESUME = 8'h40;
    localparam bit [7:0] R_CLEAR  = 8'h80;

    typedef struct packed {
        logic [7:0] pc;
        logic [2:0] depth;
        logic       halted;
        logic       fault;
    } exp_t;

    logic             clock;
    logic             reset;
    logic             step, rewind, jump, call, ret, halt, resume, clear;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc;
    logic [2:0]       depth;
    logic             halted, fault;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    pc_sequencer_if #(.WIDTH(WIDTH)) cnt_if ();

    pc_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock  (clock),
        .reset  (reset),
        .step   (step),
        .rewind (rewind),
        .jump   (jump),
        .call   (call),
        .ret    (ret),
        .target (target),
        .halt   (halt),
        .resume (resume),
        .clear  (clear),
        .cnt    (cnt_if),
        .pc     (pc),
        .depth  (depth),
        .halted (halted),
        .fault  (fault)
    );

    // Behavioural counter: async active-high reset, load, or count up/down.
    logic [WIDTH-1:0] cnt_value;
    always_ff @(posedge clock or posedge cnt_if.cnt_reset) begin
        if (cnt_if.cnt_reset) begin
            cnt_value <= '0;
        end else if (cnt_if.cnt_setvalue) begin
            cnt_value <= cnt_if.cnt_valuein;
        end else if (cnt_if.cnt_decrement) begin
            cnt_value <= cnt_value - 8'd1;
        end else begin
            cnt_value <= cnt_value + 8'd1;
        end
    end
    assign cnt_if.cnt_valueout = cnt_value;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t mk_exp(input logic [7:0] p, input int d, input logic h, input logic f);
        exp_t e;
        e.pc     = p;
        e.depth  = 3'(d);
        e.halted = h;
        e.fault  = f;
        return e;
    endfunction

    task automatic req(input bit [7:0] m, input logic [7:0] t);
        step   = m[0];
        rewind = m[1];
        jump   = m[2];
        call   = m[3];
        ret    = m[4];
        halt   = m[5];
        resume = m[6];
        clear  = m[7];
        target = t;
    endtask

    task automatic test_reset();
        req(R_STEP, 8'h00);
        @(posedge clock);
        #1;
        n_checks++;
        if (pc !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_pc: got %h want 00", pc);
        end
        n_checks++;
        if (depth !== 3'd0 || halted !== 1'b0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got depth=%0d halted=%b fault=%b want 0 0 0", depth, halted, fault);
        end
        n_checks++;
        if (cnt_if.cnt_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cnt_reset: got %b want 1", cnt_if.cnt_reset);
        end
        $display("txn reset pc=%h depth=%0d halted=%b fault=%b", pc, depth, halted, fault);
        req(R_NONE, 8'h00);
        reset = 1'b1;
        #1;
        n_checks++;
        if (cnt_if.cnt_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL release_cnt_reset: got %b want 0", cnt_if.cnt_reset);
        end
    endtask

    task automatic test_step();
        exp_t ex, got;
        for (int i = 0; i < 3; i++) begin
            req(R_STEP, 8'h00);
            sb_q.push_back(mk_exp(8'(i + 1), 0, 1'b0, 1'b0));
            #1;
            n_checks++;
            if (cnt_if.cnt_setvalue !== 1'b0 || cnt_if.cnt_decrement !== 1'b0) begin
                n_fail++;
                $display("FAIL step_ctrl[%0d]: got setvalue=%b decrement=%b want 0 0", i, cnt_if.cnt_setvalue, cnt_if.cnt_decrement);
            end
            @(posedge clock);
            #1;
            got = {pc, depth, halted, fault};
            ex  = sb_q.pop_front();
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL step[%0d]: got pc=%h depth=%0d halted=%b fault=%b, want pc=%h depth=%0d halted=%b fault=%b", i, got.pc, got.depth, got.halted, got.fault, ex.pc, ex.depth, ex.halted, ex.fault);
            end
            $display("txn step[%0d] pc=%h depth=%0d halted=%b fault=%b", i, pc, depth, halted, fault);
        end
    endtask

    task automatic test_jump_wrap();
        bit [7:0]   m [4] = '{R_JUMP, R_STEP, R_STEP, R_REW};
        logic [7:0] t [4] = '{8'hFE, 8'h00, 8'h00, 8'h00};
        logic [7:0] p [4] = '{8'hFE, 8'hFF, 8'h00, 8'hFF};
        exp_t ex, got;
        for (int i = 0; i < 4; i++) begin
            req(m[i], t[i]);
            sb_q.push_back(mk_exp(p[i], 0, 1'b0, 1'b0));
            #1;
            if (m[i] == R_REW) begin
                n_checks++;
                if (cnt_if.cnt_setvalue !== 1'b0 || cnt_if.cnt_decrement !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rewind_ctrl: got setvalue=%b decrement=%b want 0 1", cnt_if.cnt_setvalue, cnt_if.cnt_decrement);
                end
            end
            if (m[i] == R_JUMP) begin
                n_checks++;
                if (cnt_if.cnt_setvalue !== 1'b1 || cnt_if.cnt_valuein !== t[i]) begin
                    n_fail++;
                    $display("FAIL jump_ctrl: got setvalue=%b valuein=%h want 1 %h", cnt_if.cnt_setvalue, cnt_if.cnt_valuein, t[i]);
                end
            end
            @(posedge clock);
            #1;
            got = {pc, depth, halted, fault};
            ex  = sb_q.pop_front();
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL jump_wrap[%0d]: got pc=%h depth=%0d halted=%b fault=%b, want pc=%h depth=%0d halted=%b fault=%b", i, got.pc, got.depth, got.halted, got.fault, ex.pc, ex.depth, ex.halted, ex.fault);
            end
            $display("txn jump_wrap[%0d] pc=%h depth=%0d halted=%b fault=%b", i, pc, depth, halted, fault);
        end
    endtask

    task automatic test_call_ret();
        bit [7:0]   m [5] = '{R_JUMP, R_CALL, R_CALL, R_RET, R_RET};
        logic [7:0] t [5] = '{8'h10, 8'h40, 8'h80, 8'h00, 8'h00};
        exp_t       e [5];
        exp_t ex, got;
        e = '{mk_exp(8'h10, 0, 0, 0), mk_exp(8'h40, 1, 0, 0), mk_exp(8'h80, 2, 0, 0),
              mk_exp(8'h41, 1, 0, 0), mk_exp(8'h11, 0, 0, 0)};
        for (int i = 0; i < 5; i++) begin
            req(m[i], t[i]);
            sb_q.push_back(e[i]);
            @(posedge clock);
            #1;
            got = {pc, depth, halted, fault};
            ex  = sb_q.pop_front();
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL call_ret[%0d]: got pc=%h depth=%0d halted=%b fault=%b, want pc=%h depth=%0d halted=%b fault=%b", i, got.pc, got.depth, got.halted, got.fault, ex.pc, ex.depth, ex.halted, ex.fault);
            end
            $display("txn call_ret[%0d] pc=%h depth=%0d halted=%b fault=%b", i, pc, depth, halted, fault);
        end
    endtask

    task automatic test_overflow();
        bit [7:0]   m [9] = '{R_CALL, R_CALL, R_CALL, R_CALL, R_CALL, R_STEP, R_CLEAR, R_RET, R_CLEAR};
        logic [7:0] t [9] = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_t       e [9];
        exp_t ex, got;
        e = '{mk_exp(8'h20, 1, 0, 0), mk_exp(8'h30, 2, 0, 0), mk_exp(8'h40, 3, 0, 0),
              mk_exp(8'h50, 4, 0, 0), mk_exp(8'h50, 4, 0, 1), mk_exp(8'h50, 4, 0, 1),
              mk_exp(8'h50, 0, 0, 0), mk_exp(8'h50, 0, 0, 1), mk_exp(8'h50, 0, 0, 0)};
        for (int i = 0; i < 9; i++) begin
            req(m[i], t[i]);
            sb_q.push_back(e[i]);
            @(posedge clock);
            #1;
            got = {pc, depth, halted, fault};
            ex  = sb_q.pop_front();
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL overflow[%0d]: got pc=%h depth=%0d halted=%b fault=%b, want pc=%h depth=%0d halted=%b fault=%b", i, got.pc, got.depth, got.halted, got.fault, ex.pc, ex.depth, ex.halted, ex.fault);
            end
            $display("txn overflow[%0d] pc=%h depth=%0d halted=%b fault=%b", i, pc, depth, halted, fault);
        end
    endtask

    task automatic test_halt();
        exp_t ex, got;
        bit [7:0] m;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                m = R_HALT;
                sb_q.push_back(mk_exp(8'h50, 0, 1, 0));
            end else if (i < 6) begin
                m = R_STEP | R_JUMP;
                sb_q.push_back(mk_exp(8'h50, 0, 1, 0));
            end else if (i == 6) begin
                m = R_RESUME | R_STEP;
                sb_q.push_back(mk_exp(8'h50, 0, 0, 0));
            end else begin
                m = R_STEP;
                sb_q.push_back(mk_exp(8'h51, 0, 0, 0));
            end
            req(m, 8'h99);
            #1;
            if (i >= 1 && i <= 6) begin
                n_checks++;
                if (cnt_if.cnt_setvalue !== 1'b1 || cnt_if.cnt_valuein !== pc || cnt_if.cnt_decrement !== 1'b0) begin
                    n_fail++;
                    $display("FAIL halt_hold[%0d]: got setvalue=%b valuein=%h decrement=%b want 1 %h 0", i, cnt_if.cnt_setvalue, cnt_if.cnt_valuein, cnt_if.cnt_decrement, pc);
                end
            end
            @(posedge clock);
            #1;
            got = {pc, depth, halted, fault};
            ex  = sb_q.pop_front();
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL halt[%0d]: got pc=%h depth=%0d halted=%b fault=%b, want pc=%h depth=%0d halted=%b fault=%b", i, got.pc, got.depth, got.halted, got.fault, ex.pc, ex.depth, ex.halted, ex.fault);
            end
            $display("txn halt[%0d] pc=%h depth=%0d halted=%b fault=%b", i, pc, depth, halted, fault);
        end
    endtask

    task automatic test_back_to_back();
        bit [7:0]   m [9] = '{R_CALL | R_JUMP | R_STEP, R_RET | R_CALL | R_JUMP, R_HALT | R_STEP | R_JUMP,
                              R_HALT | R_RESUME, R_CLEAR | R_STEP, R_REW | R_STEP, R_JUMP, R_CALL, R_RET};
        logic [7:0] t [9] = '{8'h20, 8'h70, 8'h99, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h10, 8'h00};
        exp_t       e [9];
        exp_t ex, got;
        e = '{mk_exp(8'h20, 1, 0, 0), mk_exp(8'h52, 0, 0, 0), mk_exp(8'h52, 0, 1, 0),
              mk_exp(8'h52, 0, 0, 0), mk_exp(8'h53, 0, 0, 0), mk_exp(8'h52, 0, 0, 0),
              mk_exp(8'hFF, 0, 0, 0), mk_exp(8'h10, 1, 0, 0), mk_exp(8'h00, 0, 0, 0)};
        for (int i = 0; i < 9; i++) begin
            req(m[i], t[i]);
            sb_q.push_back(e[i]);
            @(posedge clock);
            #1;
            got = {pc, depth, halted, fault};
            ex  = sb_q.pop_front();
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got pc=%h depth=%0d halted=%b fault=%b, want pc=%h depth=%0d halted=%b fault=%b", i, got.pc, got.depth, got.halted, got.fault, ex.pc, ex.depth, ex.halted, ex.fault);
            end
            $display("txn back_to_back[%0d] pc=%h depth=%0d halted=%b fault=%b", i, pc, depth, halted, fault);
        end
    endtask

    task automatic test_reset_mid();
        bit [7:0]   m [5] = '{R_CALL, R_CALL, R_RET, R_CLEAR, R_STEP};
        logic [7:0] t [5] = '{8'h30, 8'h55, 8'h00, 8'h00, 8'h00};
        exp_t       e [5];
        exp_t ex, got;
        e = '{mk_exp(8'h30, 1, 0, 0), mk_exp(8'h55, 2, 0, 0), mk_exp(8'h00, 0, 0, 1),
              mk_exp(8'h00, 0, 0, 0), mk_exp(8'h01, 0, 0, 0)};
        for (int i = 0; i < 5; i++) begin
            req(m[i], t[i]);
            sb_q.push_back(e[i]);
            @(posedge clock);
            #1;
            got = {pc, depth, halted, fault};
            ex  = sb_q.pop_front();
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got pc=%h depth=%0d halted=%b fault=%b, want pc=%h depth=%0d halted=%b fault=%b", i, got.pc, got.depth, got.halted, got.fault, ex.pc, ex.depth, ex.halted, ex.fault);
            end
            $display("txn reset_mid[%0d] pc=%h depth=%0d halted=%b fault=%b", i, pc, depth, halted, fault);
            if (i == 1) begin
                // Mid-cycle reset with a call still pending; must clear before the next edge.
                req(R_CALL, 8'h77);
                #2;
                reset = 1'b0;
                #1;
                got = {pc, depth, halted, fault};
                n_checks++;
                if (got !== mk_exp(8'h00, 0, 0, 0) || cnt_if.cnt_reset !== 1'b1) begin
                    n_fail++;
                    $display("FAIL async_reset: got pc=%h depth=%0d halted=%b fault=%b cnt_reset=%b, want pc=00 depth=0 halted=0 fault=0 cnt_reset=1", got.pc, got.depth, got.halted, got.fault, cnt_if.cnt_reset);
                end
                $display("txn async_reset pc=%h depth=%0d halted=%b fault=%b", pc, depth, halted, fault);
                @(posedge clock);
                #1;
                req(R_NONE, 8'h00);
                reset = 1'b1;
                #1;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        req(R_NONE, 8'h00);
        test_reset();
        test_step();
        test_jump_wrap();
        test_call_ret();
        test_overflow();
        test_halt();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
